// File: rtl/gf163_digit_mult.sv
// gf163_digit_mult: digit-serial GF(2^163) multiplier, f(x) = x^163 + x^7 + x^6 + x^3 + 1.
// Walks the digits of A from the most significant one down. Each step shifts the
// accumulator by one digit, adds digit x B, and folds the overflow bits straight back in.
// Build option: define GF163_DIGIT4_EN to switch from 2-bit digits (82 steps) to
// 4-bit digits (41 steps). Ports, handshake and results are the same in both builds.

// One partial-product lane: B shifted into place for one bit of the current digit.
module gf163_pp_lane #(
  parameter int M  = 163,
  parameter int W  = 165,
  parameter int SH = 0
) (
  input  logic         en,
  input  logic [M-1:0] b,
  output logic [W-1:0] pp
);
  assign pp = en ? (W'(b) << SH) : '0;
endmodule

module gf163_digit_mult (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         MUL_START,
  input  logic [162:0] MUL_A,
  input  logic [162:0] MUL_B,
  output logic         MUL_BUSY,
  output logic         MUL_DONE,
  output logic [162:0] MUL_C
);
  localparam int M = 163;
`ifdef GF163_DIGIT4_EN
  localparam int DW = 4;
  localparam int ND = 41;
`else
  localparam int DW = 2;
  localparam int ND = 82;
`endif
  localparam int CW = $clog2(ND);
  localparam int TW = M + DW;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]               state;
  logic [ND-1:0][DW-1:0]    a_q;     // A zero-padded to ND*DW = 164 bits, one entry per digit
  logic [M-1:0]             b_q;
  logic [M-1:0]             acc;
  logic [M-1:0]             acc_nxt;
  logic [CW-1:0]            cnt;
  logic [DW-1:0]            dig;
  logic [DW-1:0][TW-1:0]    pp;
  logic [TW-1:0]            t;

  assign dig      = a_q[cnt];
  assign MUL_BUSY = (state == RUN);

  for (genvar i = 0; i < DW; i++) begin : g_lane
    gf163_pp_lane #(.M(M), .W(TW), .SH(i)) u_lane (
      .en (dig[i]),
      .b  (b_q),
      .pp (pp[i])
    );
  end

  // One digit step: shift, add the partial products, then fold the overflow bits.
  // A folded bit only reaches bits <= DW+6, so folding never creates new overflow.
  always_comb begin
    t = {acc, {DW{1'b0}}};
    for (int i = 0; i < DW; i++) t = t ^ pp[i];
    for (int j = DW - 1; j >= 0; j--) begin
      if (t[M+j]) begin
        t[j+7] = ~t[j+7];
        t[j+6] = ~t[j+6];
        t[j+3] = ~t[j+3];
        t[j]   = ~t[j];
        t[M+j] = 1'b0;
      end
    end
    acc_nxt = t[M-1:0];
  end

  // Control and datapath registers: accept a start while idle, step once per cycle,
  // and publish the result on the step that processes digit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      MUL_DONE <= 1'b0;
      MUL_C    <= '0;
    end else begin
      MUL_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (MUL_START) begin
            a_q   <= {1'b0, MUL_A};
            b_q   <= MUL_B;
            acc   <= '0;
            cnt   <= CW'(ND - 1);
            state <= RUN;
          end
        end
        default: begin
          acc <= acc_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            MUL_C    <= acc_nxt;
            MUL_DONE <= 1'b1;
            state    <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_gf163_digit_mult.sv
// Testbench for gf163_digit_mult: directed cases plus random operands, with a
// scoreboard queue filled at each accepted start and drained by a done monitor.
module tb_gf163_digit_mult;
`ifdef GF163_DIGIT4_EN
  localparam int ND = 41;
`else
  localparam int ND = 82;
`endif
  localparam logic [324:0] POLY = (325'(1) << 163) | 325'h0C9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mul_start = 1'b0;
  logic [162:0] mul_a = '0;
  logic [162:0] mul_b = '0;
  logic         mul_busy;
  logic         mul_done;
  logic [162:0] mul_c;

  int nchk = 0;
  int nerr = 0;
  int n_issued = 0;
  int n_done = 0;
  logic [162:0] sb[$];
  logic [162:0] last_c = '0;

  gf163_digit_mult dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .MUL_START (mul_start),
    .MUL_A     (mul_a),
    .MUL_B     (mul_b),
    .MUL_BUSY  (mul_busy),
    .MUL_DONE  (mul_done),
    .MUL_C     (mul_c)
  );

  always #5 clk = ~clk;

  // Reference: full schoolbook carry-less product, then long division by f.
  function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b);
    logic [324:0] p;
    p = '0;
    for (int i = 0; i < 163; i++) if (a[i]) p = p ^ (325'(b) << i);
    for (int i = 324; i >= 163; i--) if (p[i]) p = p ^ (POLY << (i - 163));
    return p[162:0];
  endfunction

  function automatic logic [162:0] rnd163();
    logic [162:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) r = {r[130:0], 32'($urandom)};
    return r;
  endfunction

  task automatic chk(input string name, input logic [162:0] act, input logic [162:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle (or in its done cycle).
  task automatic run_op(input logic [162:0] a, input logic [162:0] b, input logic [162:0] exp);
    int lat;
    mul_a = a;
    mul_b = b;
    mul_start = 1'b1;
    @(posedge clk);
    sb.push_back(exp);
    n_issued++;
    #1 mul_start = 1'b0;
    mul_a = rnd163();
    mul_b = rnd163();
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!mul_done && lat < ND + 20);
    chk("latency", 163'(lat), 163'(ND));
  endtask

  // Monitor: compare each completion against the scoreboard; check result stability while busy.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_c = '0;
    end else if (mul_done) begin
      n_done++;
      if (sb.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_done: got result %h expected no completion", mul_c);
      end else begin
        chk("result", mul_c, sb.pop_front());
      end
      last_c = mul_c;
    end else if (mul_busy) begin
      chk("c_stable", mul_c, last_c);
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL timeout: got no end of test expected finish within budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [162:0] a, b;
    int lat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 163'(mul_busy), 163'(0));
    chk("rst_done", 163'(mul_done), 163'(0));
    chk("rst_c", mul_c, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(163'd1, 163'd1, 163'd1);
    run_op(163'h2, 163'(1) << 162, 163'h0C9);
    run_op(163'h4, 163'(1) << 162, 163'h192);

    // A second start while running is ignored
    @(posedge clk); #1;
    mul_a = 163'h3; mul_b = 163'h5; mul_start = 1'b1;
    @(posedge clk);
    sb.push_back(163'hF);
    n_issued++;
    #1 mul_start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      mul_start = (lat == 10);
      if (lat == 10) mul_a = 163'h7;
      if (!mul_done) chk("busy_hold", 163'(mul_busy), 163'(1));
    end while (!mul_done && lat < ND + 20);
    mul_start = 1'b0;
    chk("latency_ignored", 163'(lat), 163'(ND));
    @(posedge clk); #1;
    chk("idle_after_ignored", 163'(mul_busy), 163'(0));
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-operation aborts with no done
    mul_a = rnd163(); mul_b = rnd163(); mul_start = 1'b1;
    @(posedge clk);
    #1 mul_start = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 163'(mul_busy), 163'(0));
    chk("abort_done", 163'(mul_done), 163'(0));
    chk("abort_c", mul_c, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(163'h4, 163'(1) << 162, 163'h192);

    // Corner operands
    run_op('0, rnd163(), '0);
    run_op({163{1'b1}}, {163{1'b1}}, ref_mul({163{1'b1}}, {163{1'b1}}));

    // Random back-to-back; each restart lands in the done cycle. Every fourth
    // pair is issued swapped against the unswapped reference (commutativity).
    for (int n = 0; n < 1000; n++) begin
      a = rnd163();
      b = rnd163();
      if ((n % 4) == 3) run_op(b, a, ref_mul(a, b));
      else              run_op(a, b, ref_mul(a, b));
    end

    repeat (ND + 5) @(posedge clk);
    #1;
    chk("done_count", 163'(n_done), 163'(n_issued));
    chk("queue_empty", 163'(sb.size()), 163'(0));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
